dac_seg_encoder: RTL and testbench

//   Digital front end of the segmented DAC: converts a binary sample code into the 7-bit binary LSB
//   and 17-bit thermometer MSB control words, plus their complements and pdb, consumed by driver_cell.

---
 rtl/dac_seg_if.sv | 47 ++++
 rtl/dac_seg_encoder.sv | 174 +++++++++++++++++
 tb/tb_dac_seg_encoder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dac_seg_if.sv
// Code-side handshake and driver-side control bundle of the segmented DAC encoder.
// The master side drives power requests and codes; the slave side drives the driver_cell controls.
interface dac_seg_if #(
    parameter int unsigned CODE_W  = 12,
    parameter int unsigned N_BIN   = 7,
    parameter int unsigned N_THERM = 17
);
    logic               en;
    logic [CODE_W-1:0]  code_in;
    logic               code_valid;
    logic               code_ready;
    logic [N_BIN-1:0]   datain;
    logic [N_BIN-1:0]   datainb;
    logic [N_THERM-1:0] datatherm;
    logic [N_THERM-1:0] datathermb;
    logic               pdb;
    logic               active;
    logic               sat_flag;

    modport master (
        output en,
        output code_in,
        output code_valid,
        input  code_ready,
        input  datain,
        input  datainb,
        input  datatherm,
        input  datathermb,
        input  pdb,
        input  active,
        input  sat_flag
    );

    modport slave (
        input  en,
        input  code_in,
        input  code_valid,
        output code_ready,
        output datain,
        output datainb,
        output datatherm,
        output datathermb,
        output pdb,
        output active,
        output sat_flag
    );
endinterface

// File: rtl/dac_seg_encoder.sv
// Segmented DAC front end: sequences driver power-up/down and turns accepted sample codes into
// binary LSB and thermometer MSB control words through a two-stage pipeline.
module dac_seg_encoder #(
    parameter int unsigned N_BIN       = 7,
    parameter int unsigned N_THERM     = 17,
    parameter int unsigned CODE_W      = 12,
    parameter int unsigned WAKE_CYCLES = 16
) (
    input logic      clk,
    input logic      rst,
    dac_seg_if.slave bus
);

    localparam int unsigned MSB_W    = CODE_W - N_BIN;
    localparam int unsigned CODE_MAX = N_THERM * (2 ** N_BIN) + (2 ** N_BIN) - 1;
    localparam int unsigned WCNT_W   = $clog2(WAKE_CYCLES + 1);
    localparam logic [CODE_W-1:0] CODE_MAX_W = CODE_W'(CODE_MAX);
    localparam logic [WCNT_W-1:0] WAKE_LAST  = WCNT_W'(WAKE_CYCLES - 1);

    typedef enum logic [1:0] {StOff, StWake, StActive, StDrain} state_e;

    state_e             state_q;
    logic [WCNT_W-1:0]  wake_cnt_q;

    logic               code_ready_q;
    logic               active_q;
    logic               pdb_q;
    logic               sat_flag_q;
    logic [N_BIN-1:0]   datain_q;
    logic [N_BIN-1:0]   datainb_q;
    logic [N_THERM-1:0] datatherm_q;
    logic [N_THERM-1:0] datathermb_q;

    // Stage 0 holds the raw accepted code, stage 1 the saturated msb/lsb split.
    logic               s0_valid_q;
    logic [CODE_W-1:0]  s0_code_q;
    logic               s1_valid_q;
    logic [MSB_W-1:0]   s1_msb_q;
    logic [N_BIN-1:0]   s1_lsb_q;
    logic               s1_sat_q;

    logic               transfer;
    logic               s0_sat;
    logic [CODE_W-1:0]  s0_code_sat;
    logic [N_THERM-1:0] therm_next;
    logic               pipe_empty;

    assign transfer   = bus.code_valid & code_ready_q;
    assign pipe_empty = ~s0_valid_q & ~s1_valid_q;

    always_comb begin
        s0_sat      = (s0_code_q > CODE_MAX_W);
        s0_code_sat = s0_sat ? CODE_MAX_W : s0_code_q;
    end

    always_comb begin
        therm_next = '0;
        for (int unsigned k = 0; k < N_THERM; k++) begin
            therm_next[k] = (k < 32'(s1_msb_q));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_q <= 1'b0;
            s0_code_q  <= '0;
            s1_valid_q <= 1'b0;
            s1_msb_q   <= '0;
            s1_lsb_q   <= '0;
            s1_sat_q   <= 1'b0;
        end else begin
            s0_valid_q <= transfer;
            if (transfer) begin
                s0_code_q <= bus.code_in;
            end
            s1_valid_q <= s0_valid_q;
            if (s0_valid_q) begin
                s1_msb_q <= s0_code_sat[CODE_W-1:N_BIN];
                s1_lsb_q <= s0_code_sat[N_BIN-1:0];
                s1_sat_q <= s0_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StOff;
            wake_cnt_q   <= '0;
            code_ready_q <= 1'b0;
            active_q     <= 1'b0;
            pdb_q        <= 1'b0;
            sat_flag_q   <= 1'b0;
            datain_q     <= '0;
            datainb_q    <= '0;
            datatherm_q  <= '0;
            datathermb_q <= '0;
        end else begin
            sat_flag_q <= 1'b0;
            // Outputs hold between emissions; only a stage-1 word refreshes them.
            if (s1_valid_q && (state_q == StActive || state_q == StDrain)) begin
                datain_q     <= s1_lsb_q;
                datainb_q    <= ~s1_lsb_q;
                datatherm_q  <= therm_next;
                datathermb_q <= ~therm_next;
                sat_flag_q   <= s1_sat_q;
            end
            unique case (state_q)
                StOff: begin
                    if (bus.en) begin
                        state_q      <= StWake;
                        wake_cnt_q   <= '0;
                        pdb_q        <= 1'b1;
                        datain_q     <= '0;
                        datainb_q    <= '1;
                        datatherm_q  <= '0;
                        datathermb_q <= '1;
                    end
                end
                StWake: begin
                    if (!bus.en) begin
                        state_q      <= StOff;
                        pdb_q        <= 1'b0;
                        datain_q     <= '0;
                        datainb_q    <= '0;
                        datatherm_q  <= '0;
                        datathermb_q <= '0;
                    end else if (wake_cnt_q == WAKE_LAST) begin
                        state_q      <= StActive;
                        code_ready_q <= 1'b1;
                        active_q     <= 1'b1;
                    end else begin
                        wake_cnt_q <= wake_cnt_q + 1'b1;
                    end
                end
                StActive: begin
                    if (!bus.en) begin
                        state_q      <= StDrain;
                        code_ready_q <= 1'b0;
                        active_q     <= 1'b0;
                    end
                end
                StDrain: begin
                    // Leave only once the last in-flight word has been on the outputs a cycle.
                    if (pipe_empty) begin
                        state_q      <= StOff;
                        pdb_q        <= 1'b0;
                        datain_q     <= '0;
                        datainb_q    <= '0;
                        datatherm_q  <= '0;
                        datathermb_q <= '0;
                    end
                end
                default: state_q <= StOff;
            endcase
        end
    end

    assign bus.code_ready = code_ready_q;
    assign bus.active     = active_q;
    assign bus.pdb        = pdb_q;
    assign bus.sat_flag   = sat_flag_q;
    assign bus.datain     = datain_q;
    assign bus.datainb    = datainb_q;
    assign bus.datatherm  = datatherm_q;
    assign bus.datathermb = datathermb_q;

    a_complements: assert property (@(posedge clk) disable iff (rst)
        pdb_q |-> (datainb_q == ~datain_q) && (datathermb_q == ~datatherm_q));
    a_thermometric: assert property (@(posedge clk) disable iff (rst)
        (datatherm_q & (datatherm_q + N_THERM'(1))) == '0);
    a_ready_only_active: assert property (@(posedge clk) disable iff (rst)
        code_ready_q |-> (state_q == StActive));

endmodule

// File: tb/tb_dac_seg_encoder.sv
// Randomized bench for dac_seg_encoder, checked every cycle against a queue-based model of
// the power sequence and the two-cycle code latency.
module tb_dac_seg_encoder;

    localparam int unsigned N_BIN       = 7;
    localparam int unsigned N_THERM     = 17;
    localparam int unsigned CODE_W      = 12;
    localparam int unsigned WAKE_CYCLES = 16;
    localparam int          CODE_MAX    = 2303;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dac_seg_if #(.CODE_W(CODE_W), .N_BIN(N_BIN), .N_THERM(N_THERM)) bus ();

    dac_seg_encoder #(
        .N_BIN      (N_BIN),
        .N_THERM    (N_THERM),
        .CODE_W     (CODE_W),
        .WAKE_CYCLES(WAKE_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: power phase, wake count, and a queue of accepted codes with due cycles.
    int   phase = 0;  // 0 off, 1 waking, 2 running, 3 draining
    int   wake_n = 0;
    int   cyc = 0;
    int   due_q[$];
    int   code_q[$];
    logic e_pdb = 0, e_ready = 0, e_active = 0, e_sat = 0;
    logic [N_BIN-1:0]   e_din = '0, e_dinb = '0;
    logic [N_THERM-1:0] e_dth = '0, e_dthb = '0;

    task automatic zero_buses();
        e_din = '0; e_dinb = '0; e_dth = '0; e_dthb = '0;
    endtask

    task automatic show_code(input int c);
        int cs, msb, lsb;
        cs  = (c > CODE_MAX) ? CODE_MAX : c;
        msb = cs / 128;
        lsb = cs % 128;
        e_din  = N_BIN'(lsb);
        e_dinb = ~e_din;
        e_dth  = N_THERM'((1 << msb) - 1);
        e_dthb = ~e_dth;
        e_sat  = (c > CODE_MAX);
    endtask

    task automatic model_edge();
        logic xfer;
        bit   was_empty;
        cyc++;
        if (rst) begin
            phase = 0;
            due_q.delete();
            code_q.delete();
            zero_buses();
            e_pdb = 0; e_ready = 0; e_active = 0; e_sat = 0;
        end else begin
            xfer      = bus.code_valid && e_ready;
            was_empty = (due_q.size() == 0);
            e_sat     = 0;
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                show_code(code_q[0]);
                void'(due_q.pop_front());
                void'(code_q.pop_front());
            end
            if (xfer) begin
                due_q.push_back(cyc + 2);
                code_q.push_back(int'(bus.code_in));
            end
            case (phase)
                0: if (bus.en) begin
                    phase = 1; wake_n = 0; e_pdb = 1;
                    e_din = '0; e_dinb = '1; e_dth = '0; e_dthb = '1;
                end
                1: if (!bus.en) begin
                    phase = 0; e_pdb = 0; zero_buses();
                end else begin
                    wake_n++;
                    if (wake_n == WAKE_CYCLES) begin
                        phase = 2; e_ready = 1; e_active = 1;
                    end
                end
                2: if (!bus.en) begin
                    phase = 3; e_ready = 0; e_active = 0;
                end
                default: if (was_empty) begin
                    phase = 0; e_pdb = 0; zero_buses();
                end
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check("pdb", 32'(bus.pdb), 32'(e_pdb));
        check("code_ready", 32'(bus.code_ready), 32'(e_ready));
        check("active", 32'(bus.active), 32'(e_active));
        check("sat_flag", 32'(bus.sat_flag), 32'(e_sat));
        check("datain", 32'(bus.datain), 32'(e_din));
        check("datainb", 32'(bus.datainb), 32'(e_dinb));
        check("datatherm", 32'(bus.datatherm), 32'(e_dth));
        check("datathermb", 32'(bus.datathermb), 32'(e_dthb));
    endtask

    task automatic bring_up(input bit measure);
        int since_pdb;
        bit done;
        since_pdb = -1;
        done = 0;
        bus.en = 1'b1;
        bus.code_valid = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            step();
            if (since_pdb >= 0) since_pdb++;
            if (bus.pdb === 1'b1 && since_pdb < 0) since_pdb = 0;
            if (bus.code_ready === 1'b1) done = 1;
        end
        check("wake_timeout", 32'(done), 32'd1);
        if (measure) check("wake_len", 32'(since_pdb), 32'(WAKE_CYCLES));
    endtask

    initial begin
        rst = 1'b1;
        bus.en = 1'b0;
        bus.code_valid = 1'b0;
        bus.code_in = '0;

        // Reset for two cycles
        step();
        step();
        check("t1_pdb", 32'(bus.pdb), 32'd0);
        check("t1_therm", 32'(bus.datatherm), 32'd0);
        rst = 1'b0;
        step();

        // Wake sequence
        bring_up(1'b1);

        // Single code 389
        bus.code_valid = 1'b1;
        bus.code_in = 12'd389;
        step();
        bus.code_valid = 1'b0;
        step();
        step();
        check("t3_therm", 32'(bus.datatherm), 32'h00007);
        check("t3_din", 32'(bus.datain), 32'h05);
        check("t3_thermb", 32'(bus.datathermb), 32'h1FFF8);
        check("t3_dinb", 32'(bus.datainb), 32'h7A);
        check("t3_sat", 32'(bus.sat_flag), 32'd0);

        // Full scale then saturated code back-to-back
        bus.code_valid = 1'b1;
        bus.code_in = 12'd2303;
        step();
        bus.code_in = 12'd4095;
        step();
        bus.code_valid = 1'b0;
        step();
        check("t4a_therm", 32'(bus.datatherm), 32'h1FFFF);
        check("t4a_din", 32'(bus.datain), 32'h7F);
        check("t4a_sat", 32'(bus.sat_flag), 32'd0);
        step();
        check("t4b_therm", 32'(bus.datatherm), 32'h1FFFF);
        check("t4b_din", 32'(bus.datain), 32'h7F);
        check("t4b_sat", 32'(bus.sat_flag), 32'd1);

        // Stream with en dropped alongside the last transfer
        bus.code_valid = 1'b1;
        bus.code_in = 12'd0;
        step();
        bus.code_in = 12'd128;
        step();
        bus.code_in = 12'd2176;
        bus.en = 1'b0;
        step();
        bus.code_valid = 1'b0;
        check("t5_ready", 32'(bus.code_ready), 32'd0);
        step();
        check("t5_mid_therm", 32'(bus.datatherm), 32'h00001);
        step();
        check("t5_last_therm", 32'(bus.datatherm), 32'h1FFFF);
        check("t5_last_pdb", 32'(bus.pdb), 32'd1);
        step();
        check("t5_off_pdb", 32'(bus.pdb), 32'd0);
        check("t5_off_therm", 32'(bus.datatherm), 32'd0);

        // Reset mid-stream, then rewake
        bring_up(1'b0);
        bus.code_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.code_in = CODE_W'($urandom_range(0, 4095));
            step();
        end
        rst = 1'b1;
        step();
        check("t6_pdb", 32'(bus.pdb), 32'd0);
        check("t6_ready", 32'(bus.code_ready), 32'd0);
        check("t6_thermb", 32'(bus.datathermb), 32'd0);
        rst = 1'b0;
        bus.code_valid = 1'b0;
        bring_up(1'b1);

        // Randomized traffic with occasional power drops and resets
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if (bus.en && $urandom_range(0, 39) == 0) bus.en = 1'b0;
            else if (!bus.en && $urandom_range(0, 7) == 0) bus.en = 1'b1;
            bus.code_valid = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       bus.code_in = CODE_W'($urandom_range(2290, 2310));
                1:       bus.code_in = CODE_W'($urandom_range(2304, 4095));
                default: bus.code_in = CODE_W'($urandom_range(0, 2303));
            endcase
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
